// File: rtl/snoop_bus_arbiter_if.sv
// Snoop-bus signal bundle between the core regions (master) and the cluster arbiter (slave).
// Slice i of every vector belongs to core i.
interface snoop_bus_arbiter_if #(
    parameter int num_cores = 2
);
    logic [6*num_cores-1:0]  snp_own_sendM_atop;
    logic [num_cores-1:0]    snp_own_sendM_valid;
    logic [num_cores-1:0]    snp_own_sendS_valid;
    logic [32*num_cores-1:0] snp_own_send_addr;
    logic [num_cores-1:0]    snp_other_sendM_valid;
    logic [32*num_cores-1:0] snp_other_sendM_addr;
    logic [num_cores-1:0]    snp_bus_exokay;
    logic [num_cores-1:0]    snp_bus_sc_gnt;

    modport master (
        output snp_own_sendM_atop,
        output snp_own_sendM_valid,
        output snp_own_sendS_valid,
        output snp_own_send_addr,
        input  snp_other_sendM_valid,
        input  snp_other_sendM_addr,
        input  snp_bus_exokay,
        input  snp_bus_sc_gnt
    );

    modport slave (
        input  snp_own_sendM_atop,
        input  snp_own_sendM_valid,
        input  snp_own_sendS_valid,
        input  snp_own_send_addr,
        output snp_other_sendM_valid,
        output snp_other_sendM_addr,
        output snp_bus_exokay,
        output snp_bus_sc_gnt
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Cluster snoop-bus arbiter: round-robin grant, write broadcast and LR/SC reservations.
// Define SNP_LRSC_EN to build reservation tracking; otherwise every grant returns exokay=1.
module snoop_bus_arbiter #(
    parameter int         num_cores  = 2,
    parameter logic [5:0] atop_sc    = 6'h01,
    parameter logic [5:0] atop_plain = 6'h00
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    snoop_bus_arbiter_if.slave    bus
);
    localparam int IW = (num_cores > 1) ? $clog2(num_cores) : 1;

    typedef enum logic {ARB, RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]           r_win, w_win_nxt;
    logic [num_cores-1:0]    r_gnt, w_gnt_nxt;
    logic [num_cores-1:0]    r_exok, w_exok_nxt;
    logic [num_cores-1:0]    r_ov, w_ov_nxt;
    logic [32*num_cores-1:0] r_oa, w_oa_nxt;

    logic [num_cores-1:0]    w_req;
    logic                    w_any;
    logic [IW-1:0]           w_win, w_lo, w_hi;
    logic                    w_found_hi;
    logic                    w_sel_m;
    logic [31:0]             w_sel_addr;
    logic [5:0]              w_sel_atop;
    logic                    w_is_sc, w_is_plain, w_is_amo;
    logic                    w_exok, w_bcast;

    assign w_req = bus.snp_own_sendM_valid | bus.snp_own_sendS_valid;
    assign w_any = |w_req;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        w_lo       = '0;
        w_hi       = '0;
        w_found_hi = 1'b0;
        for (int i = num_cores - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_lo = IW'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi       = IW'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_win = w_found_hi ? w_hi : w_lo;
    end

    always_comb begin
        w_sel_m    = 1'b0;
        w_sel_addr = '0;
        w_sel_atop = '0;
        for (int i = 0; i < num_cores; i++) begin
            if (IW'(i) == w_win) begin
                w_sel_m    = bus.snp_own_sendM_valid[i];
                w_sel_addr = bus.snp_own_send_addr[32*i +: 32];
                w_sel_atop = bus.snp_own_sendM_atop[6*i +: 6];
            end
        end
    end

    assign w_is_sc    = (w_sel_atop == atop_sc);
    assign w_is_plain = (w_sel_atop == atop_plain);
    assign w_is_amo   = !w_is_sc && !w_is_plain;

`ifdef SNP_LRSC_EN
    logic [num_cores-1:0] r_res_v, w_res_v_nxt;
    logic [29:0]          r_res_a     [num_cores];
    logic [29:0]          w_res_a_nxt [num_cores];
    logic [num_cores-1:0] w_match;
    logic                 w_own_hit;

    // Reservations are updated on the same edge that latches the winner.
    always_comb begin
        w_match     = '0;
        w_own_hit   = 1'b0;
        w_res_v_nxt = r_res_v;
        w_res_a_nxt = r_res_a;
        w_exok      = 1'b0;
        w_bcast     = 1'b0;
        for (int i = 0; i < num_cores; i++) begin
            w_match[i] = r_res_v[i] && (r_res_a[i] == w_sel_addr[31:2]);
            if (IW'(i) == w_win) begin
                w_own_hit = w_match[i];
            end
        end
        if (!w_sel_m) begin
            w_exok = 1'b1;
        end else if (w_is_sc) begin
            w_exok  = w_own_hit;
            w_bcast = w_own_hit;
        end else if (w_is_plain || w_is_amo) begin
            w_bcast = 1'b1;
        end
        if (r_state == ARB && w_any) begin
            for (int j = 0; j < num_cores; j++) begin
                if (!w_sel_m) begin
                    if (IW'(j) == w_win) begin
                        w_res_v_nxt[j] = 1'b1;
                        w_res_a_nxt[j] = w_sel_addr[31:2];
                    end
                end else if (w_is_sc) begin
                    if ((w_own_hit && w_match[j]) || IW'(j) == w_win) begin
                        w_res_v_nxt[j] = 1'b0;
                    end
                end else if (w_match[j] && IW'(j) != w_win) begin
                    w_res_v_nxt[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_res_v <= '0;
            for (int i = 0; i < num_cores; i++) begin
                r_res_a[i] <= '0;
            end
        end else begin
            r_res_v <= w_res_v_nxt;
            for (int i = 0; i < num_cores; i++) begin
                r_res_a[i] <= w_res_a_nxt[i];
            end
        end
    end
`else
    always_comb begin
        w_exok  = 1'b1;
        w_bcast = w_sel_m && (w_is_sc || w_is_plain || w_is_amo);
    end
`endif

    // Outputs are computed in ARB and registered so they are high only during RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = '0;
        w_exok_nxt  = '0;
        w_ov_nxt    = '0;
        w_oa_nxt    = '0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_state_nxt = RESP;
                    w_win_nxt   = w_win;
                    for (int i = 0; i < num_cores; i++) begin
                        if (IW'(i) == w_win) begin
                            w_gnt_nxt[i]  = 1'b1;
                            w_exok_nxt[i] = w_exok;
                        end else if (w_bcast) begin
                            w_ov_nxt[i]          = 1'b1;
                            w_oa_nxt[32*i +: 32] = w_sel_addr;
                        end
                    end
                end
            end
            RESP: begin
                w_state_nxt = ARB;
                w_rr_nxt    = (int'(r_win) == num_cores - 1) ? '0 : r_win + 1'b1;
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_gnt    <= '0;
            r_exok   <= '0;
            r_ov     <= '0;
            r_oa     <= '0;
        end else begin
            r_rr_ptr <= w_rr_nxt;
            r_win    <= w_win_nxt;
            r_gnt    <= w_gnt_nxt;
            r_exok   <= w_exok_nxt;
            r_ov     <= w_ov_nxt;
            r_oa     <= w_oa_nxt;
        end
    end

    assign bus.snp_bus_sc_gnt        = r_gnt;
    assign bus.snp_bus_exokay        = r_exok;
    assign bus.snp_other_sendM_valid = r_ov;
    assign bus.snp_other_sendM_addr  = r_oa;
endmodule
